// File: rtl/read_iq_if.sv
// Handshake bundle between read_iq, the upstream raw-IQ FIFO and the two FIR input FIFOs.
interface read_iq_if #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8
);
  logic [BYTE_SIZE-1:0] in_dout;
  logic                 in_empty;
  logic                 in_rd_en;
  logic [DATA_SIZE-1:0] i_out_din;
  logic                 i_out_full;
  logic                 i_out_wr_en;
  logic [DATA_SIZE-1:0] q_out_din;
  logic                 q_out_full;
  logic                 q_out_wr_en;

  modport slave (
    input  in_dout, in_empty, i_out_full, q_out_full,
    output in_rd_en, i_out_din, i_out_wr_en, q_out_din, q_out_wr_en
  );

  modport master (
    output in_dout, in_empty, i_out_full, q_out_full,
    input  in_rd_en, i_out_din, i_out_wr_en, q_out_din, q_out_wr_en
  );
endinterface

// File: rtl/read_iq.sv
// Assembles I_lo, I_hi, Q_lo, Q_hi bytes into sign-extended I/Q samples for the FIR FIFOs.
// Optional feature macro READ_IQ_QUANTIZE_EN: when defined, samples are left-shifted by BITS.
module read_iq #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  parameter int BITS      = 10
) (
  input  logic       clock,
  input  logic       reset,
  read_iq_if.slave   bus
);

  localparam int PAIR_W = 2 * BYTE_SIZE;
`ifdef READ_IQ_QUANTIZE_EN
  localparam int SHIFT_AMT = BITS;
`else
  localparam int SHIFT_AMT = (BITS > 0) ? 0 : 0;
`endif

  typedef enum logic [2:0] {
    S_I_LO  = 3'd0,
    S_I_HI  = 3'd1,
    S_Q_LO  = 3'd2,
    S_Q_HI  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BYTE_SIZE-1:0] i_lo_q, i_lo_d;
  logic [BYTE_SIZE-1:0] i_hi_q, i_hi_d;
  logic [BYTE_SIZE-1:0] q_lo_q, q_lo_d;
  logic [DATA_SIZE-1:0] i_out_din_q, i_out_din_d;
  logic [DATA_SIZE-1:0] q_out_din_q, q_out_din_d;
  logic                 rd_en_s;
  logic                 wr_en_s;

  function automatic logic [DATA_SIZE-1:0] shape(input logic [PAIR_W-1:0] pair);
    logic [DATA_SIZE-1:0] ext;
    ext   = DATA_SIZE'(signed'(pair));
    shape = ext << SHIFT_AMT;
  endfunction

  // Strobes are gated by reset so nothing pops or writes while reset is held.
  always_comb begin
    rd_en_s     = reset && (state_q != S_WRITE) && !bus.in_empty;
    wr_en_s     = reset && (state_q == S_WRITE) && !bus.i_out_full && !bus.q_out_full;
    state_d     = state_q;
    i_lo_d      = i_lo_q;
    i_hi_d      = i_hi_q;
    q_lo_d      = q_lo_q;
    i_out_din_d = i_out_din_q;
    q_out_din_d = q_out_din_q;
    case (state_q)
      S_I_LO: begin
        if (rd_en_s) begin
          i_lo_d  = bus.in_dout;
          state_d = S_I_HI;
        end else begin
          state_d = S_I_LO;
        end
      end
      S_I_HI: begin
        if (rd_en_s) begin
          i_hi_d  = bus.in_dout;
          state_d = S_Q_LO;
        end else begin
          state_d = S_I_HI;
        end
      end
      S_Q_LO: begin
        if (rd_en_s) begin
          q_lo_d  = bus.in_dout;
          state_d = S_Q_HI;
        end else begin
          state_d = S_Q_LO;
        end
      end
      S_Q_HI: begin
        // Q_hi goes straight into the output register, no holding byte needed.
        if (rd_en_s) begin
          i_out_din_d = shape({i_hi_q, i_lo_q});
          q_out_din_d = shape({bus.in_dout, q_lo_q});
          state_d     = S_WRITE;
        end else begin
          state_d = S_Q_HI;
        end
      end
      S_WRITE: begin
        if (wr_en_s) begin
          state_d = S_I_LO;
        end else begin
          state_d = S_WRITE;
        end
      end
      default: state_d = S_I_LO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_I_LO;
      i_lo_q      <= '0;
      i_hi_q      <= '0;
      q_lo_q      <= '0;
      i_out_din_q <= '0;
      q_out_din_q <= '0;
    end else begin
      state_q     <= state_d;
      i_lo_q      <= i_lo_d;
      i_hi_q      <= i_hi_d;
      q_lo_q      <= q_lo_d;
      i_out_din_q <= i_out_din_d;
      q_out_din_q <= q_out_din_d;
    end
  end

  assign bus.in_rd_en    = rd_en_s;
  assign bus.i_out_wr_en = wr_en_s;
  assign bus.q_out_wr_en = wr_en_s;
  assign bus.i_out_din   = i_out_din_q;
  assign bus.q_out_din   = q_out_din_q;

endmodule

// File: tb/tb_read_iq.sv
// Directed bench for read_iq; expected samples depend on READ_IQ_QUANTIZE_EN.
module tb_read_iq;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  read_iq_if #(.DATA_SIZE(32), .BYTE_SIZE(8)) bus ();

  read_iq #(.DATA_SIZE(32), .BYTE_SIZE(8), .BITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

`ifdef READ_IQ_QUANTIZE_EN
  localparam logic [31:0] EXP_A_I = 32'h0048_D000;
  localparam logic [31:0] EXP_A_Q = 32'h0159_E000;
  localparam logic [31:0] EXP_B_I = 32'hFE00_0000;
  localparam logic [31:0] EXP_B_Q = 32'hFFFF_FC00;
  localparam logic [31:0] EXP_R_I = 32'h0159_E000;
  localparam logic [31:0] EXP_R_Q = 32'hFE6A_F000;  // 0xFFFF9ABC << 10, truncated
`else
  localparam logic [31:0] EXP_A_I = 32'h0000_1234;
  localparam logic [31:0] EXP_A_Q = 32'h0000_5678;
  localparam logic [31:0] EXP_B_I = 32'hFFFF_8000;
  localparam logic [31:0] EXP_B_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_R_I = 32'h0000_5678;
  localparam logic [31:0] EXP_R_Q = 32'hFFFF_9ABC;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop(input logic [7:0] b);
    bus.in_dout  = b;
    bus.in_empty = 1'b0;
    @(negedge clock);
    check("pop_rd_en", {31'd0, bus.in_rd_en}, 32'd1);
    check("pop_no_wr", {30'd0, bus.i_out_wr_en, bus.q_out_wr_en}, 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic expect_write(input logic [31:0] ei, input logic [31:0] eq);
    bus.in_empty = 1'b0;
    bus.in_dout  = 8'hA5;
    @(negedge clock);
    check("wr_i_en", {31'd0, bus.i_out_wr_en}, 32'd1);
    check("wr_q_en", {31'd0, bus.q_out_wr_en}, 32'd1);
    check("wr_rd_en", {31'd0, bus.in_rd_en}, 32'd0);
    check("wr_i_din", bus.i_out_din, ei);
    check("wr_q_din", bus.q_out_din, eq);
    @(posedge clock); #1;
    bus.in_empty = 1'b1;
    @(negedge clock);
    check("wr_one_cycle", {30'd0, bus.i_out_wr_en, bus.q_out_wr_en}, 32'd0);
    check("din_held", bus.i_out_din, ei);
    @(posedge clock); #1;
  endtask

  initial begin
    bus.in_dout    = 8'h00;
    bus.in_empty   = 1'b0;
    bus.i_out_full = 1'b0;
    bus.q_out_full = 1'b0;

    // Reset state with a non-empty FIFO: no strobes, zero outputs.
    @(negedge clock);
    check("rst_rd_en", {31'd0, bus.in_rd_en}, 32'd0);
    check("rst_wr_en", {30'd0, bus.i_out_wr_en, bus.q_out_wr_en}, 32'd0);
    check("rst_i_din", bus.i_out_din, 32'd0);
    check("rst_q_din", bus.q_out_din, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Back-to-back bytes.
    pop(8'h34); pop(8'h12); pop(8'h78); pop(8'h56);
    expect_write(EXP_A_I, EXP_A_Q);

    // Negative sign extension.
    pop(8'h00); pop(8'h80); pop(8'hFF); pop(8'hFF);
    expect_write(EXP_B_I, EXP_B_Q);

    // Q FIFO full for three cycles on entering the write state.
    pop(8'h34); pop(8'h12); pop(8'h78);
    bus.q_out_full = 1'b1;
    pop(8'h56);
    bus.in_empty = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("full_no_wr", {30'd0, bus.i_out_wr_en, bus.q_out_wr_en}, 32'd0);
      check("full_rd_en", {31'd0, bus.in_rd_en}, 32'd0);
      check("full_i_din", bus.i_out_din, EXP_A_I);
      check("full_q_din", bus.q_out_din, EXP_A_Q);
      @(posedge clock); #1;
    end
    bus.q_out_full = 1'b0;
    expect_write(EXP_A_I, EXP_A_Q);

    // Two empty cycles before every byte.
    for (int k = 0; k < 4; k++) begin
      bus.in_empty = 1'b1;
      bus.in_dout  = 8'hEE;
      for (int c = 0; c < 2; c++) begin
        @(negedge clock);
        check("empty_rd_en", {31'd0, bus.in_rd_en}, 32'd0);
        @(posedge clock); #1;
      end
      case (k)
        0: pop(8'h34);
        1: pop(8'h12);
        2: pop(8'h78);
        default: pop(8'h56);
      endcase
    end
    expect_write(EXP_A_I, EXP_A_Q);

    // Reset mid-sample discards the partial sample.
    pop(8'h34); pop(8'h12);
    reset        = 1'b0;
    bus.in_empty = 1'b0;
    @(negedge clock);
    check("mid_rst_rd_en", {31'd0, bus.in_rd_en}, 32'd0);
    check("mid_rst_wr_en", {30'd0, bus.i_out_wr_en, bus.q_out_wr_en}, 32'd0);
    check("mid_rst_i_din", bus.i_out_din, 32'd0);
    check("mid_rst_q_din", bus.q_out_din, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    pop(8'h78); pop(8'h56); pop(8'hBC); pop(8'h9A);
    expect_write(EXP_R_I, EXP_R_Q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
